// File: rtl/dsp_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp_seq
// Brief    : Load/sweep sequencer that feeds one dsp shift-register instance
//            from a valid/ready stream and streams its readback words out.
// Revision : 1.0
// ============================================================================
module dsp_seq #(
  parameter int BUS_WIDTH   = 24,
  parameter int LOAD_WORDS  = 2,
  parameter int READ_WORDS  = 2,
  parameter int PARAM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BUS_WIDTH-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BUS_WIDTH-1:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   dsp_en,
  output logic                   dsp_we,
  output logic [BUS_WIDTH-1:0]   dsp_din,
  output logic [PARAM_WIDTH-1:0] dsp_param,
  input  logic [BUS_WIDTH-1:0]   dsp_dout
);

  localparam int LCW = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;
  localparam int RIW = (READ_WORDS > 1) ? $clog2(READ_WORDS) : 1;
  localparam logic [LCW-1:0] c_LOAD_LAST = LCW'(LOAD_WORDS - 1);
  localparam logic [RIW-1:0] c_READ_LAST = RIW'(READ_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SET  = 3'd2,
    S_CAP  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LCW-1:0]         r_load_cnt;
  logic [RIW-1:0]         r_idx;
  logic [PARAM_WIDTH-1:0] r_param;
  logic [BUS_WIDTH-1:0]   r_out_data;
  logic                   r_out_valid;
  logic                   r_done;

  logic                   w_hs_in;
  logic                   w_hs_out;
  logic                   w_load_last;
  logic                   w_read_last;
  logic [RIW-1:0]         w_idx_inc;

  assign w_hs_in     = (r_state == S_LOAD) & in_valid;
  assign w_hs_out    = (r_state == S_HOLD) & r_out_valid & out_ready;
  assign w_load_last = (r_load_cnt == c_LOAD_LAST);
  assign w_read_last = (r_idx == c_READ_LAST);
  assign w_idx_inc   = r_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_hs_in && w_load_last) w_state_nxt = S_SET;
      S_SET:   w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_HOLD;
      S_HOLD:  if (w_hs_out) w_state_nxt = w_read_last ? S_IDLE : S_SET;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Abort only clears the handshake flag; counters are re-armed by the next start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_load_cnt  <= '0;
      r_idx       <= '0;
      r_param     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_out_valid <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: if (start) r_load_cnt <= '0;
          S_LOAD: begin
            if (w_hs_in) begin
              if (w_load_last) begin
                r_param <= '0;
                r_idx   <= '0;
              end else begin
                r_load_cnt <= r_load_cnt + 1'b1;
              end
            end
          end
          S_CAP: begin
            r_out_data  <= dsp_dout;
            r_out_valid <= 1'b1;
          end
          S_HOLD: begin
            if (w_hs_out) begin
              r_out_valid <= 1'b0;
              if (w_read_last) begin
                r_done <= 1'b1;
              end else begin
                r_idx   <= w_idx_inc;
                r_param <= PARAM_WIDTH'(w_idx_inc);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign dsp_we    = in_valid & in_ready;
  assign dsp_din   = in_data;
  assign busy      = (r_state != S_IDLE);
  assign dsp_en    = busy;
  assign dsp_param = r_param;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_valid & w_read_last;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dsp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_seq
// Brief    : Scoreboard bench for dsp_seq with a behavioural two-word dsp.
// Revision : 1.0
// ============================================================================
module tb_dsp_seq;

  localparam int BUS_WIDTH   = 24;
  localparam int LOAD_WORDS  = 2;
  localparam int READ_WORDS  = 2;
  localparam int PARAM_WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [BUS_WIDTH-1:0]   in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [BUS_WIDTH-1:0]   out_data;
  logic                   out_last;
  logic                   busy;
  logic                   done;
  logic                   dsp_en;
  logic                   dsp_we;
  logic [BUS_WIDTH-1:0]   dsp_din;
  logic [PARAM_WIDTH-1:0] dsp_param;
  logic [BUS_WIDTH-1:0]   dsp_dout = '0;

  dsp_seq #(
    .BUS_WIDTH  (BUS_WIDTH),
    .LOAD_WORDS (LOAD_WORDS),
    .READ_WORDS (READ_WORDS),
    .PARAM_WIDTH(PARAM_WIDTH)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .dsp_en   (dsp_en),
    .dsp_we   (dsp_we),
    .dsp_din  (dsp_din),
    .dsp_param(dsp_param),
    .dsp_dout (dsp_dout)
  );

  always #5 clk = ~clk;

  // Behavioural dsp: new word shifts into slot 0, dout registered from param.
  logic [BUS_WIDTH-1:0] m_sr [0:1];
  initial begin
    m_sr[0] = '0;
    m_sr[1] = '0;
  end
  always @(posedge clk) begin
    if (dsp_en && dsp_we) begin
      m_sr[0] <= dsp_din;
      m_sr[1] <= m_sr[0];
    end
    dsp_dout <= m_sr[dsp_param[0]];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int last_we_cyc = 0;
  int out_idx = 0;
  bit chk_idle = 1'b0;
  logic prev_ov = 1'b0;
  logic [BUS_WIDTH-1:0] sb[$];
  int rises[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: scoreboard pop on every accepted word.
  always @(negedge clk) begin
    if (rstn) begin
      if (dsp_we) begin
        we_cnt++;
        last_we_cyc = cyc;
      end
      if (done) done_cnt++;
      if (out_valid && !prev_ov) rises.push_back(cyc);
      if (chk_idle) begin
        chk("busy_after_last", {31'd0, busy}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk_idle = 1'b0;
      end
      if (out_valid && out_ready && !abort) begin
        chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          chk("out_data", 32'(out_data), 32'(sb.pop_front()));
          chk("out_last", {31'd0, out_last}, {31'd0, out_idx == READ_WORDS - 1});
        end
        if (out_idx == READ_WORDS - 1) begin
          out_idx  = 0;
          chk_idle = 1'b1;
        end else begin
          out_idx++;
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_word(input logic [BUS_WIDTH-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    sb.push_front(w);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      step();
      k++;
    end
    chk("done_within_budget", 32'(done_cnt - n0), 32'd1);
  endtask

  task automatic flush_sb();
    sb.delete();
    out_idx  = 0;
    chk_idle = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    int d0;
    int k;
    logic [BUS_WIDTH-1:0] hold_d;
    logic [3:0] pat;

    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_dsp_we", {31'd0, dsp_we}, 32'd0);
    chk("rst_dsp_en", {31'd0, dsp_en}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_param", 32'(dsp_param), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rstn = 1'b1;
    step();

    // Basic job with latency measurement
    out_ready = 1'b1;
    we0 = we_cnt;
    d0  = done_cnt;
    rises.delete();
    start_job();
    chk("load_in_ready", {31'd0, in_ready}, 32'd1);
    load_word(24'h111111);
    load_word(24'h222222);
    wait_done(40);
    repeat (3) step();
    chk("basic_we_pulses", 32'(we_cnt - we0), 32'd2);
    chk("basic_done_once", 32'(done_cnt - d0), 32'd1);
    chk("basic_rise_count", 32'(rises.size()), 32'd2);
    if (rises.size() == 2) begin
      chk("lat_load_to_valid", 32'(rises[0] - last_we_cyc), 32'd3);
      chk("lat_output_gap", 32'(rises[1] - rises[0]), 32'd3);
    end

    // Downstream backpressure in HOLD
    out_ready = 1'b0;
    start_job();
    load_word(24'h333333);
    load_word(24'h444444);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    hold_d = out_data;
    chk("bp_first_data", 32'(hold_d), 32'h444444);
    we0 = we_cnt;
    repeat (5) begin
      step();
      chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_data_held", 32'(out_data), 32'(hold_d));
      chk("bp_param_held", 32'(dsp_param), 32'd0);
      chk("bp_no_we", {31'd0, dsp_we}, 32'd0);
    end
    chk("bp_we_count", 32'(we_cnt - we0), 32'd0);
    out_ready = 1'b1;
    wait_done(40);
    repeat (2) step();

    // Upstream stall pattern 1,0,0,1
    we0 = we_cnt;
    start_job();
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      in_valid = pat[i];
      in_data  = (i == 0) ? 24'hAAAAAA : ((i == 3) ? 24'hBBBBBB : 24'h5A5A5A);
      if (pat[i]) sb.push_front(in_data);
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stall_we_align", {31'd0, dsp_we}, {31'd0, pat[i]});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_done(40);
    repeat (2) step();
    chk("stall_we_pulses", 32'(we_cnt - we0), 32'd2);

    // Start ignored in CAP, abort in HOLD with concurrent handshake
    out_ready = 1'b0;
    start_job();
    load_word(24'h555555);
    load_word(24'h666666);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_data", 32'(out_data), 32'h666666);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    d0 = done_cnt;
    abort     = 1'b1;
    out_ready = 1'b1;
    step();
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    flush_sb();
    repeat (3) step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    start_job();
    load_word(24'h777777);
    load_word(24'h888888);
    wait_done(40);
    repeat (2) step();

    // Asynchronous reset mid-LOAD
    start_job();
    load_word(24'h999999);
    in_valid = 1'b1;
    in_data  = 24'hDDDDDD;
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_dsp_we", {31'd0, dsp_we}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    flush_sb();
    repeat (2) step();
    chk("arst_param", 32'(dsp_param), 32'd0);
    rstn = 1'b1;
    step();
    start_job();
    load_word(24'hBBBBBB);
    load_word(24'hCCCCCC);
    wait_done(40);
    repeat (2) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsp_seq.md
Name: dsp_seq

Overview:
Sequencer for the dsp shift-register datapath. On a start command it accepts LOAD_WORDS words from an upstream valid/ready stream and writes them into the dsp shift register through its we/din port. It then sweeps the dsp param index from 0 to READ_WORDS-1, captures each registered dsp dout word and presents it on a downstream valid/ready stream. It sits between the host stream fabric and a single dsp instance and owns that instance's en, we, din and param inputs.

Parameters:
bus_width, 24, word width of stream data, dsp_din and dsp_dout
load_words, 2, words written per job (1..255)
read_words, 2, words read back per job (1..256); index k is driven on dsp_param
param_width, 8, width of dsp_param

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  job request, sampled only in IDLE
abort  in  1  synchronous abort, highest priority after reset
in_valid  in  1  upstream word valid
in_ready  out  1  upstream ready
in_data  in  bus_width  upstream word
out_valid  out  1  downstream word valid
out_ready  in  1  downstream ready
out_data  out  bus_width  downstream word
out_last  out  1  marks final word of job
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse after final output handshake
dsp_en  out  1  to dsp en; equals busy
dsp_we  out  1  to dsp we
dsp_din  out  bus_width  to dsp din
dsp_param  out  param_width  to dsp param
dsp_dout  in  bus_width  from dsp dout (registered inside dsp, 1-cycle latency from param)

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; load count=0; read index=0; dsp_param=0; out_data=0; out_valid=0; done=0. in_ready, dsp_we, busy and dsp_en are all 0. The same applies when reset is asserted mid-job; no partial output survives.
- States: IDLE, LOAD, SET, CAP, HOLD.
- IDLE: start=1 -> LOAD with load count=0. start is ignored in every other state; there is no queueing.
- LOAD: in_ready=1 combinationally.
  - dsp_we = in_valid & in_ready; dsp_din = in_data combinationally. No register stage sits on the write path.
  - On each handshake, load count increments.
  - On the handshake with load count=load_words-1: dsp_param<=0, read index<=0, next state is SET.
  - in_valid=0 simply stalls LOAD; there is no timeout.
- SET: one cycle, during which dsp registers dout for the new param. Next state is CAP.
- CAP: one cycle. At its closing edge: out_data<=dsp_dout, out_valid<=1, next state is HOLD.
- HOLD: out_valid=1; out_data is held stable until handshake.
  - out_last = out_valid & (read index=read_words-1).
  - On out_valid & out_ready:
    - Not last word: out_valid<=0, index++, dsp_param<=index+1, next state is SET.
    - Last word: out_valid<=0, done<=1 for exactly the next cycle, next state is IDLE.
- Timing:
  - The final load handshake at edge W gives out_valid=1 from edge W+2.
  - A handshake at edge H gives the next out_valid from edge H+2.
  - Peak rate is one output per 3 cycles.
- abort=1 at a clock edge in any state -> IDLE, out_valid<=0, done stays 0.
  - abort wins over a simultaneous handshake or start.
  - The dsp shift-register contents are not cleared.
- Ordering: the dsp shifts each newly written word into its LSBs. With load_words=read_words=2, index 0 returns the last word loaded and index 1 the first.
- dsp_param is a zero-extended read index. read_words-1 must fit in param_width.
- Widths: the counters are sized by clog2 of their parameter, minimum 1 bit. Neither counter wraps: the terminal compare always fires first.

Test Plan:
- Basic job (defaults): start; load 0x111111 then 0x222222 with in_valid held. Required: two dsp_we pulses; out_data=0x222222, then 0x111111 with out_last=1; done pulses once; busy falls the cycle after the final handshake.
- Latency: out_ready held 1. Required: out_valid rises exactly 2 edges after the final load handshake; the gap between the two outputs is 3 cycles.
- Backpressure: out_ready=0 for 5 cycles in HOLD. Required: out_data and out_valid held stable; dsp_param unchanged; no dsp_we.
- Upstream stall: in_valid toggles 1,0,0,1. Required: exactly 2 dsp_we pulses aligned with the handshakes; in_ready=1 throughout LOAD.
- Ignored start / abort: start pulsed in CAP -> no effect. abort in HOLD concurrent with out_ready=1 -> IDLE, no done, out_valid=0 next cycle. A new start then completes normally.
- Async reset: rstn low mid-LOAD, asynchronous to clk. Required: busy, in_ready and dsp_we drop immediately. After release, a new job produces correct data.
